// File: rtl/ready_list_ckpt.sv
// Physical-register ready tracker: speculative and retirement vectors, plus
// branch checkpoints that snapshot the speculative vector for early recovery.

module ready_list_lane #(
  parameter int PRF     = 64,
  parameter int PRF_IDX = $clog2(PRF)
) (
  input  logic               cdb_en,
  input  logic [PRF_IDX-1:0] cdb_idx,
  input  logic               ren_req,
  input  logic [PRF_IDX-1:0] ren_dest,
  input  logic               ret_en,
  input  logic [PRF_IDX-1:0] ret_new,
  input  logic [PRF_IDX-1:0] ret_old,
  output logic [PRF-1:0]     cdb_oh,
  output logic [PRF-1:0]     ren_oh,
  output logic [PRF-1:0]     new_oh,
  output logic [PRF-1:0]     old_oh
);
  assign cdb_oh = cdb_en  ? (PRF'(1) << cdb_idx)  : '0;
  assign ren_oh = ren_req ? (PRF'(1) << ren_dest) : '0;
  assign new_oh = ret_en  ? (PRF'(1) << ret_new)  : '0;
  assign old_oh = ret_en  ? (PRF'(1) << ret_old)  : '0;
endmodule

module ready_list_ckpt #(
  parameter int N         = 2,
  parameter int PRF       = 64,
  parameter int ARCH_REGS = 32,
  parameter int NUM_CKPT  = 4,
  parameter int PRF_IDX   = $clog2(PRF),
  parameter int CKPT_IDX  = $clog2(NUM_CKPT),
  parameter int LANE_W    = $clog2(N+1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic [N-1:0]                cdb_en,
  input  logic [N-1:0][PRF_IDX-1:0]   cdb_idx,
  input  logic [N-1:0]                ren_req,
  input  logic [N-1:0][PRF_IDX-1:0]   ren_dest,
  input  logic [N-1:0][PRF_IDX-1:0]   rs1_idx,
  input  logic [N-1:0][PRF_IDX-1:0]   rs2_idx,
  input  logic [N-1:0]                ret_en,
  input  logic [N-1:0][PRF_IDX-1:0]   ret_new,
  input  logic [N-1:0][PRF_IDX-1:0]   ret_old,
  input  logic                        ckpt_save,
  input  logic [CKPT_IDX-1:0]         ckpt_save_id,
  input  logic [LANE_W-1:0]           ckpt_save_lane,
  input  logic                        ckpt_rest,
  input  logic [CKPT_IDX-1:0]         ckpt_rest_id,
  output logic [N-1:0]                rs1_ready,
  output logic [N-1:0]                rs2_ready,
  output logic [PRF-1:0]              ready_vec,
  output logic [NUM_CKPT-1:0]         ckpt_live
);
  localparam logic [PRF-1:0] RST_VEC = {{(PRF-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};

  logic [PRF-1:0]               spec_q, spec_d, arch_q, arch_d;
  logic [NUM_CKPT-1:0][PRF-1:0] slot_q, slot_d;
  logic [NUM_CKPT-1:0]          live_q, live_d;

  logic [N-1:0][PRF-1:0] cdb_oh, ren_oh, new_oh, old_oh;
  logic [N:0][PRF-1:0]   t;
  logic [PRF-1:0]        cdb_tot, ret_set, ret_clr, arch_next, save_vec;
  logic                  rest_hit;

  for (genvar k = 0; k < N; k++) begin : g_lane
    ready_list_lane #(.PRF(PRF), .PRF_IDX(PRF_IDX)) u_lane (
      .cdb_en  (cdb_en[k]),
      .cdb_idx (cdb_idx[k]),
      .ren_req (ren_req[k]),
      .ren_dest(ren_dest[k]),
      .ret_en  (ret_en[k]),
      .ret_new (ret_new[k]),
      .ret_old (ret_old[k]),
      .cdb_oh  (cdb_oh[k]),
      .ren_oh  (ren_oh[k]),
      .new_oh  (new_oh[k]),
      .old_oh  (old_oh[k])
    );
  end

  // Rename chain: lane k reads t[k], so earlier lanes' dests look busy and
  // CDB wakeups bypass into the same-cycle reads.
  always_comb begin
    cdb_tot   = '0;
    ret_set   = '0;
    ret_clr   = '0;
    rs1_ready = '0;
    rs2_ready = '0;
    for (int k = 0; k < N; k++) begin
      cdb_tot |= cdb_oh[k];
      ret_set |= new_oh[k];
      ret_clr |= old_oh[k];
    end
    t[0] = spec_q | cdb_tot;
    for (int k = 0; k < N; k++) begin
      rs1_ready[k] = t[k][rs1_idx[k]];
      rs2_ready[k] = t[k][rs2_idx[k]];
      t[k+1]       = t[k] & ~ren_oh[k];
    end
    arch_next = (arch_q & ~ret_clr) | ret_set;
    save_vec  = t[N];
    for (int l = 0; l < N; l++)
      if (ckpt_save_lane == LANE_W'(l)) save_vec = t[l];
  end

  assign rest_hit = ckpt_rest & live_q[ckpt_rest_id];

  always_comb begin
    spec_d = t[N];
    arch_d = arch_next;
    live_d = live_q;
    for (int i = 0; i < NUM_CKPT; i++)
      slot_d[i] = live_q[i] ? (slot_q[i] | cdb_tot) : slot_q[i];
    if (squash) begin
      spec_d = arch_next;
      live_d = '0;
    end else if (rest_hit) begin
      spec_d = slot_q[ckpt_rest_id] | cdb_tot;
      live_d[ckpt_rest_id] = 1'b0;
    end else if (ckpt_save) begin
      slot_d[ckpt_save_id] = save_vec;
      live_d[ckpt_save_id] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spec_q <= RST_VEC;
      arch_q <= RST_VEC;
      slot_q <= '0;
      live_q <= '0;
    end else begin
      spec_q <= spec_d;
      arch_q <= arch_d;
      slot_q <= slot_d;
      live_q <= live_d;
    end
  end

  assign ready_vec = spec_q;
  assign ckpt_live = live_q;
endmodule

// File: tb/tb_ready_list_ckpt.sv
// Bench for ready_list_ckpt: directed scenarios with literal expectations, then
// random traffic checked every cycle against a set-based behavioural model.
module tb_ready_list_ckpt;
  localparam int N = 2, PRF = 64, ARCH_REGS = 32, NUM_CKPT = 4;
  localparam int PRF_IDX = $clog2(PRF), CKPT_IDX = $clog2(NUM_CKPT), LANE_W = $clog2(N+1);

  logic                      clock, reset, squash;
  logic [N-1:0]              cdb_en, ren_req, ret_en;
  logic [N-1:0][PRF_IDX-1:0] cdb_idx, ren_dest, rs1_idx, rs2_idx, ret_new, ret_old;
  logic                      ckpt_save, ckpt_rest;
  logic [CKPT_IDX-1:0]       ckpt_save_id, ckpt_rest_id;
  logic [LANE_W-1:0]         ckpt_save_lane;
  logic [N-1:0]              rs1_ready, rs2_ready;
  logic [PRF-1:0]            ready_vec;
  logic [NUM_CKPT-1:0]       ckpt_live;

  int checks = 0, failures = 0, nonlive_rest = 0;

  ready_list_ckpt #(.N(N), .PRF(PRF), .ARCH_REGS(ARCH_REGS), .NUM_CKPT(NUM_CKPT)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .cdb_en(cdb_en), .cdb_idx(cdb_idx), .ren_req(ren_req), .ren_dest(ren_dest),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .ret_en(ret_en), .ret_new(ret_new), .ret_old(ret_old),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id), .ckpt_save_lane(ckpt_save_lane),
    .ckpt_rest(ckpt_rest), .ckpt_rest_id(ckpt_rest_id),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready), .ready_vec(ready_vec), .ckpt_live(ckpt_live)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: registers as plain bit sets; readiness from set membership.
  bit [PRF-1:0] m_spec, m_arch;
  bit [PRF-1:0] m_slot [NUM_CKPT];
  bit [NUM_CKPT-1:0] m_live;

  function automatic bit woke(int p);
    for (int k = 0; k < N; k++) if (cdb_en[k] && int'(cdb_idx[k]) == p) return 1'b1;
    return 1'b0;
  endfunction

  // Ready as seen by a reader at position `lane`: ready or woken, and not
  // claimed as a destination by any earlier lane in the group.
  function automatic bit avail(int p, int lane);
    if (!(m_spec[p] || woke(p))) return 1'b0;
    for (int j = 0; j < lane; j++) if (ren_req[j] && int'(ren_dest[j]) == p) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit [PRF-1:0] view(int lane);
    bit [PRF-1:0] v;
    for (int p = 0; p < PRF; p++) v[p] = avail(p, lane);
    return v;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < PRF; p++) begin
        m_spec[p] = (p < ARCH_REGS);
        m_arch[p] = (p < ARCH_REGS);
      end
      for (int i = 0; i < NUM_CKPT; i++) m_slot[i] = '0;
      m_live = '0;
    end else begin
      bit [PRF-1:0] na, ns, w;
      bit st, cl;
      int rid, sid, sl;
      rid = int'(ckpt_rest_id);
      sid = int'(ckpt_save_id);
      sl  = (int'(ckpt_save_lane) > N) ? N : int'(ckpt_save_lane);
      for (int p = 0; p < PRF; p++) begin
        st = 0; cl = 0;
        for (int k = 0; k < N; k++) begin
          if (ret_en[k] && int'(ret_new[k]) == p) st = 1;
          if (ret_en[k] && int'(ret_old[k]) == p) cl = 1;
        end
        na[p] = st ? 1'b1 : (cl ? 1'b0 : m_arch[p]);
        w[p]  = woke(p);
      end
      if (ckpt_rest && !m_live[rid] && !squash) nonlive_rest++;
      if (squash) begin
        ns = na;
        m_live = '0;
        for (int i = 0; i < NUM_CKPT; i++) m_slot[i] = m_slot[i] | w;
      end else if (ckpt_rest && m_live[rid]) begin
        ns = m_slot[rid] | w;
        for (int i = 0; i < NUM_CKPT; i++) if (m_live[i]) m_slot[i] = m_slot[i] | w;
        m_live[rid] = 1'b0;
      end else begin
        ns = view(N);
        for (int i = 0; i < NUM_CKPT; i++) if (m_live[i]) m_slot[i] = m_slot[i] | w;
        if (ckpt_save) begin
          m_slot[sid] = view(sl);
          m_live[sid] = 1'b1;
        end
      end
      m_spec = ns;
      m_arch = na;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    bit [N-1:0] e1, e2;
    for (int k = 0; k < N; k++) begin
      e1[k] = avail(int'(rs1_idx[k]), k);
      e2[k] = avail(int'(rs2_idx[k]), k);
    end
    chk("rs1_ready", 64'(rs1_ready), 64'(e1));
    chk("rs2_ready", 64'(rs2_ready), 64'(e2));
    chk("ready_vec", 64'(ready_vec), 64'(m_spec));
    chk("ckpt_live", 64'(ckpt_live), 64'(m_live));
  end

  task automatic idle();
    squash = 0; cdb_en = '0; ren_req = '0; ret_en = '0;
    cdb_idx = '0; ren_dest = '0; rs1_idx = '0; rs2_idx = '0; ret_new = '0; ret_old = '0;
    ckpt_save = 0; ckpt_save_id = '0; ckpt_save_lane = '0; ckpt_rest = 0; ckpt_rest_id = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic rand_in();
    for (int k = 0; k < N; k++) begin
      cdb_en[k]   = ($urandom_range(0, 2) == 0);
      cdb_idx[k]  = PRF_IDX'($urandom_range(0, PRF-1));
      ren_req[k]  = ($urandom_range(0, 1) == 0);
      ren_dest[k] = PRF_IDX'($urandom_range(0, PRF-1));
      rs1_idx[k]  = PRF_IDX'($urandom_range(0, PRF-1));
      rs2_idx[k]  = PRF_IDX'($urandom_range(0, PRF-1));
      ret_en[k]   = ($urandom_range(0, 2) == 0);
      ret_new[k]  = PRF_IDX'($urandom_range(0, PRF-1));
      ret_old[k]  = PRF_IDX'($urandom_range(0, PRF-1));
    end
    squash         = ($urandom_range(0, 39) == 0);
    ckpt_save      = ($urandom_range(0, 4) == 0);
    ckpt_save_id   = CKPT_IDX'($urandom_range(0, NUM_CKPT-1));
    ckpt_save_lane = LANE_W'($urandom_range(0, N));
    ckpt_rest      = ($urandom_range(0, 7) == 0);
    ckpt_rest_id   = CKPT_IDX'($urandom_range(0, NUM_CKPT-1));
  endtask

  initial begin
    idle();
    reset = 0;
    #1 reset = 1;
    #1;
    chk("reset_vec", 64'(ready_vec), 64'h0000_0000_FFFF_FFFF);
    chk("reset_live", 64'(ckpt_live), 64'h0);
    repeat (2) @(posedge clock);
    #1 reset = 0;

    // same-group dependency
    step(); cdb_en[0] = 1; cdb_idx[0] = 40;
    step(); chk("dep_pre", 64'(ready_vec[40]), 64'h1);
    ren_req[0] = 1; ren_dest[0] = 40; rs1_idx[0] = 40; rs1_idx[1] = 40;
    #1 chk("dep_rs1", 64'(rs1_ready), 64'h1);
    step(); chk("dep_clr", 64'(ready_vec[40]), 64'h0);

    // CDB bypass and rename-vs-CDB conflict
    cdb_en = 2'b11; cdb_idx[0] = 45; cdb_idx[1] = 46; rs2_idx[0] = 45;
    ren_req[0] = 1; ren_dest[0] = 46;
    #1 chk("byp_rs2", 64'(rs2_ready[0]), 64'h1);
    step(); chk("byp_45", 64'(ready_vec[45]), 64'h1);
    chk("conf_46", 64'(ready_vec[46]), 64'h0);

    // checkpoint save / restore
    cdb_en = 2'b11; cdb_idx[0] = 50; cdb_idx[1] = 51;
    step(); ren_req = 2'b11; ren_dest[0] = 50; ren_dest[1] = 51;
    ckpt_save = 1; ckpt_save_id = 2; ckpt_save_lane = 1;
    step(); chk("ck_busy", 64'(ready_vec[51:50]), 64'h0);
    chk("ck_live", 64'(ckpt_live), 64'h4);
    step();
    step(); cdb_en[0] = 1; cdb_idx[0] = 50;
    step(); ckpt_rest = 1; ckpt_rest_id = 2; ren_req[0] = 1; ren_dest[0] = 7;
    step(); chk("ck_rest", 64'(ready_vec[51:50]), 64'h3);
    chk("ck_ignren", 64'(ready_vec[7]), 64'h1);
    chk("ck_freed", 64'(ckpt_live), 64'h0);

    // squash with retire
    ckpt_save = 1; ckpt_save_id = 1; ckpt_save_lane = 0;
    step(); chk("sq_live_pre", 64'(ckpt_live), 64'h2);
    ret_en[0] = 1; ret_new[0] = 33; ret_old[0] = 5; squash = 1;
    step(); chk("sq_vec", 64'(ready_vec), 64'h0000_0002_FFFF_FFDF);
    chk("sq_live", 64'(ckpt_live), 64'h0);

    // restore of a non-live slot behaves as a normal cycle
    cdb_en[0] = 1; cdb_idx[0] = 60;
    step(); chk("nl_pre", 64'(ready_vec), 64'h1000_0002_FFFF_FFDF);
    ckpt_rest = 1; ckpt_rest_id = 3; ren_req[0] = 1; ren_dest[0] = 60;
    step(); chk("nl_vec", 64'(ready_vec), 64'h0000_0002_FFFF_FFDF);
    chk("nl_live", 64'(ckpt_live), 64'h0);

    repeat (3000) begin step(); rand_in(); end

    // reset mid-run
    @(posedge clock);
    #2 reset = 1;
    #1 chk("mid_reset_vec", 64'(ready_vec), 64'h0000_0000_FFFF_FFFF);
    chk("mid_reset_live", 64'(ckpt_live), 64'h0);
    repeat (2) @(posedge clock);
    #1 reset = 0;
    repeat (200) begin step(); rand_in(); end
    step();
    @(negedge clock);
    #1;
    $display("note: %0d restore requests targeted a non-live slot", nonlive_rest);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ready_list_ckpt.md
Name: ready_list_ckpt

Overview:
- Parametrised N-wide physical-register ready-bit tracker for the rename stage.
- Holds a speculative ready vector and a retirement (architectural) ready vector.
- Adds NUM_CKPT branch checkpoints that snapshot the speculative vector, so a mispredicted branch can be recovered early without waiting for retirement.
- Sits between rename (source-ready lookup, dest clear), the CDB (wakeup), the ROB (retire) and the branch stack (checkpoint save/restore).

Parameters:
- N, 2, superscalar width (rename/CDB/retire lanes).
- PRF, 64, number of physical registers.
- ARCH_REGS, 32, architectural registers; PRF 0..ARCH_REGS-1 are ready at reset.
- NUM_CKPT, 4, number of checkpoint slots.
- PRF_IDX, $clog2(PRF), derived; physical index width.
- CKPT_IDX, $clog2(NUM_CKPT), derived; checkpoint index width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- squash  in  1  full flush; restore speculative state from the architectural vector
- cdb_en  in  N  per-lane CDB broadcast valid
- cdb_idx  in  N*PRF_IDX  per-lane broadcast physical index
- ren_req  in  N  per-lane rename has a destination
- ren_dest  in  N*PRF_IDX  per-lane newly allocated physical destination
- rs1_idx, rs2_idx  in  N*PRF_IDX  per-lane source physical indices
- ret_en  in  N  per-lane ROB retire valid
- ret_new, ret_old  in  N*PRF_IDX  retiring new and old (freed) physical registers
- ckpt_save  in  1  take a snapshot this cycle
- ckpt_save_id  in  CKPT_IDX  slot to write
- ckpt_save_lane  in  $clog2(N+1)  number of rename lanes included in the snapshot (0..N)
- ckpt_rest  in  1  restore from a checkpoint
- ckpt_rest_id  in  CKPT_IDX  slot to restore
- rs1_ready, rs2_ready  out  N  per-lane source ready
- ready_vec  out  PRF  current registered speculative vector (debug/scoreboard)
- ckpt_live  out  NUM_CKPT  slot holds a valid snapshot

Behaviour:
- Reset (async, any time): spec and arch vectors = bits [ARCH_REGS-1:0] set, others clear; all snapshots = 0; ckpt_live = 0. Output values during reset follow from these registers.
- Combinational chain each cycle:
  - t[0] = spec | OR over lanes of onehot(cdb_idx) where cdb_en is set. CDB bypasses to same-cycle reads.
  - t[k+1] = t[k] & ~onehot(ren_dest[k]) if ren_req[k], else t[k].
  - rs1_ready[k] = t[k][rs1_idx[k]]; same for rs2. A later lane sees an earlier lane's dest as not ready, and its own dest is not cleared before its own read.
- Rename beats CDB when the same index appears on both in one cycle: the clear wins.
- arch_next = (arch & ~OR of onehot(ret_old)) | OR of onehot(ret_new), over retiring lanes. Set beats clear on the same index.
- Snapshots:
  - Every live slot ORs in the cycle's CDB one-hot total each cycle, so wakeups after the snapshot are kept.
  - On ckpt_save: slot[ckpt_save_id] <= t[ckpt_save_lane] and ckpt_live bit is set.
  - A save to a live slot overwrites it.
- Priority, registered on the clock edge:
  1. squash: spec <= arch_next; arch <= arch_next; ckpt_live <= 0; save and restore are ignored.
  2. ckpt_rest with ckpt_live[ckpt_rest_id] = 1: spec <= slot[ckpt_rest_id] | cdb total; this cycle's ren_req are ignored (younger wrong-path work); ckpt_save is ignored; ckpt_live <= 0 for that slot. Other slots are left untouched; the branch stack frees younger slots by not restoring them.
  3. ckpt_rest to a non-live slot: no restore, the cycle proceeds as normal (error case; the bench flags it).
  4. Normal: spec <= t[N]. arch updates every cycle except during reset.
- Latency: ready reads are combinational, 0 cycles. State updates are visible the next cycle.
- Wrap/full: the slot pool is managed externally; there is no internal full flag.

Test Plan:
- Reset mid-run, N=2/PRF=64: assert reset -> ready_vec = 64'h0000_0000_FFFF_FFFF immediately; ckpt_live = 0.
- Same-group dependency: lane0 ren_dest=40, lane1 rs1_idx=40, spec[40]=1 -> rs1_ready[1]=0, rs1_ready[0]=1 for rs1_idx[0]=40; next cycle ready_vec[40]=0.
- CDB bypass and conflict: cdb_idx=45 with lane0 rs2_idx=45 -> rs2_ready[0]=1 in the same cycle; cdb_idx=46 with ren_dest=46 in the same cycle -> ready_vec[46]=0 next cycle.
- Checkpoint restore:
  - Save slot 2 with lane=1 after lane0 renames 50; lane1 renames 51.
  - Two cycles later CDB sets 50; then ckpt_rest id=2.
  - Expect ready_vec[50]=1, ready_vec[51] = pre-rename value, ckpt_live[2]=0.
- Squash with retire: arch has 33 clear; ret_new=33, ret_old=5, squash=1 -> ready_vec[33]=1, ready_vec[5]=0, ckpt_live=0.
- Restore of non-live slot 3 with ren_req lane0 dest=60 -> treated as normal: ready_vec[60]=0, other bits unchanged.
